// File: rtl/bfloat_pkg.sv
// Shared bfloat16 constants, field layout and helpers for the multiplier normalize stage.
package bfloat_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int E_W   = 10;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [15:0]      QNAN    = 16'h7FC0;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } bf16_t;

  // Operand classification resolved in S1 so S2 only has to pick a pattern.
  typedef enum logic [1:0] {
    KIND_NORM = 2'd0,
    KIND_NAN  = 2'd1,
    KIND_ZERO = 2'd2,
    KIND_INF  = 2'd3
  } kind_e;

  function automatic logic [15:0] signed_inf(input logic s);
    return {s, EXP_MAX, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [15:0] signed_zero(input logic s);
    return {s, {(EXP_W + MAN_W){1'b0}}};
  endfunction

endpackage

// File: rtl/bfloat_round.sv
// Combinational mantissa rounding; BFLOAT_RNE_EN selects round-to-nearest-even,
// otherwise the mantissa is truncated and guard/sticky are ignored.
module bfloat_round
  import bfloat_pkg::*;
(
  input  logic [MAN_W-1:0]      man_i,
  input  logic                  guard_i,
  input  logic                  sticky_i,
  input  logic signed [E_W-1:0] exp_i,
  output logic [MAN_W-1:0]      man_o,
  output logic signed [E_W-1:0] exp_o
);

`ifdef BFLOAT_RNE_EN
  logic           inc;
  logic [MAN_W:0] sum;

  assign inc = guard_i & (sticky_i | man_i[0]);
  assign sum = {1'b0, man_i} + {{MAN_W{1'b0}}, inc};

  // A carry out of the 7-bit fraction leaves it all-zero and bumps the exponent.
  assign man_o = sum[MAN_W-1:0];
  assign exp_o = exp_i + {{(E_W-1){1'b0}}, sum[MAN_W]};
`else
  logic unused_round;

  assign unused_round = guard_i ^ sticky_i;
  assign man_o        = man_i;
  assign exp_o        = exp_i;
`endif

endmodule

// File: rtl/bfloat_mult_normalize.sv
// Two-stage bfloat16 multiplier back end: S1 aligns the product and forms the exponent,
// S2 rounds and packs. Define BFLOAT_RNE_EN for round-to-nearest-even (default: truncate).
module bfloat_mult_normalize
  import bfloat_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [15:0] prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  logic                  s1_valid_q;
  logic                  s1_sign_q,   s1_sign_d;
  kind_e                 s1_kind_q,   s1_kind_d;
  logic signed [E_W-1:0] s1_exp_q,    s1_exp_d;
  logic [MAN_W-1:0]      s1_man_q,    s1_man_d;
  logic                  s1_guard_q,  s1_guard_d;
  logic                  s1_sticky_q, s1_sticky_d;

  logic                  out_valid_q;
  logic [15:0]           out_q,       out_d;

  logic                  s1_ready;
  logic                  s2_ready;
  logic [MAN_W-1:0]      man_r;
  logic signed [E_W-1:0] exp_r;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = rst || s1_ready;

  // S1: classify operands, pick the significand window by the product's leading bit.
  always_comb begin
    s1_sign_d  = sign_a ^ sign_b;
    s1_kind_d  = KIND_NORM;
    if (exp_a == EXP_MAX || exp_b == EXP_MAX) begin
      s1_kind_d = (exp_a == '0 || exp_b == '0) ? KIND_NAN : KIND_INF;
    end else if (exp_a == '0 || exp_b == '0) begin
      s1_kind_d = KIND_ZERO;
    end
    s1_exp_d = {2'b00, exp_a} + {2'b00, exp_b} + {{(E_W-1){1'b0}}, prod[15]} - 10'(BIAS);
    if (prod[15]) begin
      s1_man_d   = prod[14:8];
      s1_guard_d = prod[7];
    end else begin
      s1_man_d   = prod[13:7];
      s1_guard_d = prod[6];
    end
  end

`ifdef BFLOAT_RNE_EN
  assign s1_sticky_d = prod[15] ? (|prod[6:0]) : (|prod[5:0]);
`else
  logic unused_prod;

  assign unused_prod = ^prod[5:0];
  assign s1_sticky_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_kind_q   <= KIND_NORM;
      s1_exp_q    <= '0;
      s1_man_q    <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q   <= s1_sign_d;
        s1_kind_q   <= s1_kind_d;
        s1_exp_q    <= s1_exp_d;
        s1_man_q    <= s1_man_d;
        s1_guard_q  <= s1_guard_d;
        s1_sticky_q <= s1_sticky_d;
      end
    end
  end

  bfloat_round u_round (
    .man_i    (s1_man_q),
    .guard_i  (s1_guard_q),
    .sticky_i (s1_sticky_q),
    .exp_i    (s1_exp_q),
    .man_o    (man_r),
    .exp_o    (exp_r)
  );

  // S2 pack; overflow/underflow are judged on the post-rounding exponent.
  always_comb begin
    bf16_t res;
    res.sign = s1_sign_q;
    res.exp  = exp_r[EXP_W-1:0];
    res.man  = man_r;
    out_d    = res;
    if (s1_kind_q == KIND_NAN) begin
      out_d = QNAN;
    end else if (s1_kind_q == KIND_ZERO) begin
      out_d = signed_zero(s1_sign_q);
    end else if (s1_kind_q == KIND_INF || exp_r >= 10'sd255) begin
      out_d = signed_inf(s1_sign_q);
    end else if (exp_r <= 10'sd0) begin
      out_d = signed_zero(s1_sign_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= 16'h0000;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q <= out_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_bfloat_mult_normalize.sv
// Scoreboarded bench for bfloat_mult_normalize; expectations track BFLOAT_RNE_EN if defined.
module tb_bfloat_mult_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sign_a = 1'b0;
  logic        sign_b = 1'b0;
  logic [7:0]  exp_a = 8'd0;
  logic [7:0]  exp_b = 8'd0;
  logic [15:0] prod = 16'h4000;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;

  int errors = 0;
  int checks = 0;
  int acceptCount = 0;
  int outCount = 0;
  logic [15:0] expQ[$];

  bfloat_mult_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Reference model written from the arithmetic definition with plain integers.
  function automatic logic [15:0] model(input logic sa, input logic sb, input logic [7:0] ea,
                                        input logic [7:0] eb, input logic [15:0] p);
    logic s;
    int   e;
    int   m;
    logic g;
    logic st;
    logic inc;
    logic [7:0] e8;
    logic [6:0] m7;
    s = sa ^ sb;
    if (ea == 8'd255 || eb == 8'd255) return (ea == 8'd0 || eb == 8'd0) ? 16'h7FC0 : {s, 8'hFF, 7'h00};
    if (ea == 8'd0 || eb == 8'd0) return {s, 15'h0000};
    e = int'(ea) + int'(eb) - 127;
    if (p[15]) begin
      e  = e + 1;
      m  = int'(p[14:8]);
      g  = p[7];
      st = |p[6:0];
    end else begin
      m  = int'(p[13:7]);
      g  = p[6];
      st = |p[5:0];
    end
    inc = g && (st || (m % 2 == 1));
`ifndef BFLOAT_RNE_EN
    inc = 1'b0;
`endif
    if (inc) m = m + 1;
    if (m == 128) begin
      m = 0;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 7'h00};
    if (e <= 0) return {s, 15'h0000};
    e8 = e[7:0];
    m7 = m[6:0];
    return {s, e8, m7};
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer, flush on reset.
  always @(negedge clk) begin
    logic [15:0] want;
    if (rst) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        outCount++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_unexpected: got out=%h, expected no output", out);
        end else begin
          want = expQ.pop_front();
          if (out !== want) begin
            errors++;
            $display("[TB] FAIL scoreboard_data: got out=%h, expected %h", out, want);
          end
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(model(sign_a, sign_b, exp_a, exp_b, prod));
        acceptCount++;
      end
    end
  end

  task automatic send(input logic sa, input logic sb, input logic [7:0] ea,
                      input logic [7:0] eb, input logic [15:0] p);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    sign_a = sa;
    sign_b = sb;
    exp_a = ea;
    exp_b = eb;
    prod = p;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: pending=%0d, expected 0", expQ.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state: got out_valid=%b out=%h, expected 0/0000", out_valid, out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(1'b0, 1'b0, 8'd127, 8'd127, 16'h4000);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: got out_valid=%b one cycle after accept, expected 0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h3F80) begin
      errors++;
      $display("[TB] FAIL latency_two: got out_valid=%b out=%h, expected 1/3f80", out_valid, out);
    end
    drain();
  endtask

  typedef struct {
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [15:0] p;
    logic [15:0] want;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [15:0] tieUp;
    logic [15:0] carryUp;
    int n;
`ifdef BFLOAT_RNE_EN
    tieUp   = 16'h3F82;
    carryUp = 16'h4000;
`else
    tieUp   = 16'h3F81;
    carryUp = 16'h3FFF;
`endif
    v.push_back('{1'b0, 1'b0, 8'd127, 8'd127, 16'h4000, 16'h3F80});
    v.push_back('{1'b0, 1'b0, 8'd127, 8'd127, 16'h9000, 16'h4010});
    v.push_back('{1'b0, 1'b0, 8'd127, 8'd127, 16'h4040, 16'h3F80});
    v.push_back('{1'b0, 1'b0, 8'd127, 8'd127, 16'h40C0, tieUp});
    v.push_back('{1'b0, 1'b0, 8'd127, 8'd127, 16'h7FC0, carryUp});
    v.push_back('{1'b0, 1'b0, 8'd127, 8'd127, 16'hFE01, 16'h407E});
    v.push_back('{1'b1, 1'b0, 8'd254, 8'd254, 16'h4000, 16'hFF80});
    v.push_back('{1'b0, 1'b0, 8'd60,  8'd60,  16'h4000, 16'h0000});
    v.push_back('{1'b1, 1'b0, 8'd60,  8'd60,  16'h4000, 16'h8000});
    v.push_back('{1'b0, 1'b0, 8'd254, 8'd127, 16'h4000, 16'h7F00});
    v.push_back('{1'b0, 1'b0, 8'd254, 8'd128, 16'h4000, 16'h7F80});
    v.push_back('{1'b0, 1'b0, 8'd1,   8'd127, 16'h4000, 16'h0080});
    v.push_back('{1'b1, 1'b1, 8'd1,   8'd126, 16'h4000, 16'h0000});
    v.push_back('{1'b0, 1'b1, 8'd255, 8'd0,   16'h4000, 16'h7FC0});
    v.push_back('{1'b1, 1'b0, 8'd255, 8'd10,  16'h4000, 16'hFF80});
    v.push_back('{1'b0, 1'b1, 8'd0,   8'd200, 16'hFE01, 16'h8000});
    out_ready = 1'b1;
    foreach (v[i]) begin
      send(v[i].sa, v[i].sb, v[i].ea, v[i].eb, v[i].p);
      in_valid = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (out_valid !== 1'b1 && n < 10);
      checks++;
      if (out_valid !== 1'b1 || out !== v[i].want) begin
        errors++;
        $display("[TB] FAIL directed_%0d: got out_valid=%b out=%h, expected 1/%h", i, out_valid, out, v[i].want);
      end
      @(posedge clk);
      #1;
    end
    drain();
  endtask

  task automatic test_backpressure();
    int baseAcc;
    int baseOut;
    logic [15:0] holdVal;
    baseAcc = acceptCount;
    baseOut = outCount;
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 1'b0, 8'd127, 8'd127, 16'h4000);
        send(1'b1, 1'b0, 8'd127, 8'd127, 16'h9000);
        send(1'b0, 1'b0, 8'd127, 8'd128, 16'h4000);
        send(1'b0, 1'b1, 8'd130, 8'd127, 16'h8000);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || acceptCount - baseAcc != 2) begin
          errors++;
          $display("[TB] FAIL bp_stall: got in_ready=%b accepted=%0d, expected 0/2", in_ready, acceptCount - baseAcc);
        end
        holdVal = out;
        checks++;
        if (out_valid !== 1'b1 || holdVal !== 16'h3F80) begin
          errors++;
          $display("[TB] FAIL bp_head: got out_valid=%b out=%h, expected 1/3f80", out_valid, holdVal);
        end
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out !== holdVal || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got out_valid=%b out=%h in_ready=%b, expected 1/%h/0", out_valid, out, in_ready, holdVal);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (outCount - baseOut != 4) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d outputs, expected 4", outCount - baseOut);
    end
  endtask

  task automatic test_back_to_back();
    int baseOut;
    bit done;
    baseOut = outCount;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               16'($urandom_range(128, 255) * $urandom_range(128, 255)));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (outCount - baseOut != 40) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d outputs, expected 40", outCount - baseOut);
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    send(1'b0, 1'b0, 8'd127, 8'd127, 16'h9000);
    send(1'b1, 1'b0, 8'd127, 8'd127, 16'h4000);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 16'h0000 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_reset: got out_valid=%b out=%h in_ready=%b, expected 0/0000/1", out_valid, out, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_stale: got out_valid=%b out=%h, expected 0", out_valid, out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bfloat_mult_normalize.md
BFLOAT_MULT_NORMALIZE -- requirements
Module: bfloat_mult_normalize

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state on posedge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream product/exponent bundle valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts the bundle this cycle.
REQ-005 SHALL have ports sign_a and sign_b, input, 1 each, operand signs.
REQ-006 SHALL have ports exp_a and exp_b, input, 8 each, biased operand exponents.
REQ-007 SHALL have port prod, input, 16, unsigned product of two 8-bit significands (1.7 format), range [0x4000, 0xFE01].
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port out, output, 16, bfloat16 result {sign, exp[7:0], man[6:0]}.

Function
REQ-011 SHALL transfer on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
REQ-012 SHALL be a two-stage registered pipeline: S1 = align+exponent, S2 = round+pack; latency 2 cycles from input transfer to out_valid with no stall.
REQ-013 SHALL set stage readiness as S2 ready = !s2_valid||out_ready and S1 ready = !s1_valid||S2 ready; in_ready equals S1 ready, so full throughput of 1 per cycle is sustained.
REQ-014 SHALL hold out and out_valid stable while out_valid&&!out_ready.
REQ-015 SHALL compute sign = sign_a^sign_b.
REQ-016 SHALL compute a 10-bit signed exponent e = exp_a+exp_b-127 (+1 if prod[15]).
REQ-017 SHALL select the mantissa, guard and sticky by prod[15]: if prod[15]=1, man=prod[14:8], guard=prod[7], sticky=|prod[6:0]; otherwise man=prod[13:7], guard=prod[6], sticky=|prod[5:0].
REQ-018 SHALL apply rounding on mantissa carry-out: man=0 and e=e+1.
REQ-019 SHALL, when e>=255 after rounding, output signed infinity {sign,8'hFF,7'h0}.
REQ-020 SHALL, when e<=0 after rounding, flush to signed zero (no denormals).
REQ-021 SHALL output signed zero when exp_a==0 or exp_b==0 (zero/denormal operand), regardless of prod.
REQ-022 SHALL, when exp_a==255 or exp_b==255, output 16'h7FC0 if the other exponent is 0, else signed infinity.
REQ-023 SHALL apply the special cases with priority: NaN case, then zero operand, then overflow, then underflow.

Reset
REQ-024 SHALL, on rst, clear s1_valid, s2_valid and out_valid to 0 and out to 16'h0000 on the next posedge.
REQ-025 SHALL discard in-flight data when rst is asserted mid-operation; no result emerges for it.
REQ-026 SHALL hold in_ready at 1 during rst.

Configuration
REQ-027 SHALL, when BFLOAT_RNE_EN is defined, round to nearest even: increment if guard&&(sticky||man[0]).
REQ-028 SHALL, when BFLOAT_RNE_EN is undefined, truncate (never increment), removing the rounding adder and sticky logic.

Structure
REQ-029 SHALL place BIAS=127, EXP_MAX=8'hFF, QNAN=16'h7FC0 and the bfloat16 field widths/typedef in shared package bfloat_pkg.
REQ-030 SHALL implement rounding in combinational sub-module bfloat_round (man, guard, sticky, e in -> man, e out), instantiated in S2.

Verification
REQ-031 SHALL be verified with exp_a=exp_b=127, prod=0x4000 (1.0*1.0) -> out=0x3F80 two cycles later.
REQ-032 SHALL be verified with exp 127/127, prod=0x9000 (1.5*1.5) -> out=0x4010.
REQ-033 SHALL be verified, with BFLOAT_RNE_EN defined, with prod=0x4040 -> 0x3F80 (tie to even) and prod=0x40C0 -> 0x3F82; without the macro, 0x40C0 -> 0x3F81.
REQ-034 SHALL be verified with exp_a=exp_b=254, sign_a=1 -> out=0xFF80; exp_a=exp_b=60 -> out=0x0000 or 0x8000 per sign.
REQ-035 SHALL be verified by streaming 4 bundles with out_ready low for 3 cycles -> in_ready drops after 2 accepted, out holds, then all 4 emerge in order without loss or duplication.
REQ-036 SHALL be verified by asserting rst with 2 bundles in flight -> out_valid=0 and out=0x0000 next cycle, and no stale result after release.
